// File: rtl/ym2413_bus_write_sequencer.sv
// ym2413_bus_write_sequencer
//
// Queues OPLL register writes arriving as (address, data) pairs and replays
// each one onto the YM2413-style host bus as an address strobe followed by a
// data strobe. It also spaces them so the core never sees writes closer
// together than the real chip accepts: a settle period after reset, and
// address/data write-wait gaps after each strobe.
//
// Ports
//   clk         clock (XIN rate, shared with the OPLL core)
//   rst_n       asynchronous active-low reset
//   i_wr_valid  write request valid
//   i_wr_addr   OPLL register address
//   i_wr_data   OPLL register data
//   o_wr_ready  queue can accept a push (low while booting or full)
//   o_CS_n      chip select to core, active low (registered)
//   o_WR_n      write strobe to core, active low (registered)
//   o_A0        0 = address phase, 1 = data phase (registered)
//   o_D         bus data to core (registered)
//   o_busy      sequencer not idle, or queue non-empty
//   o_overflow  one-cycle pulse when a request is dropped
//
// ADDR_WAIT, DATA_WAIT and BOOT_WAIT are expected to be at least 1.
// FIFO_DEPTH must be a power of two, at least 2.
module ym2413_bus_write_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 4,
  parameter int ADDR_WAIT     = 12,
  parameter int DATA_WAIT     = 84,
  parameter int BOOT_WAIT     = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_valid,
  input  logic [7:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_ready,
  output logic       o_CS_n,
  output logic       o_WR_n,
  output logic       o_A0,
  output logic [7:0] o_D,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int MAX_BD = (BOOT_WAIT > DATA_WAIT) ? BOOT_WAIT : DATA_WAIT;
  localparam int MAX_AS = (ADDR_WAIT > STROBE_CYCLES) ? ADDR_WAIT : STROBE_CYCLES;
  localparam int CNT_MAX = (MAX_BD > MAX_AS) ? MAX_BD : MAX_AS;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_WAIT - 1);
  localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AGAP_LOAD = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] DGAP_LOAD = CNT_W'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    ADDR_STB,
    ADDR_GAP,
    DATA_STB,
    DATA_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [15:0]      head;
  logic             full;
  logic             push;
  logic             pop;

  logic [7:0]       data_q, data_d;
  logic             cs_n_d, wr_n_d, a0_d;
  logic [7:0]       d_d;

  // Queue front end: accept/drop decisions are combinational on the request.
  assign full       = (count_q == DEPTH_C);
  assign o_wr_ready = (state_q != BOOT) && !full;
  assign push       = i_wr_valid && o_wr_ready;
  assign o_overflow = i_wr_valid && (state_q != BOOT) && full;
  assign o_busy     = (state_q != IDLE) || (count_q != '0);
  assign head       = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {i_wr_addr, i_wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sequencer: the bus values are computed for the next state and registered,
  // so a strobe is low for exactly the cycles the FSM spends in a *_STB state
  // and A0/D can only move on the edge that starts a strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cs_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    a0_d    = o_A0;
    d_d     = o_D;
    pop     = 1'b0;
    case (state_q)
      BOOT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          data_d  = head[7:0];
          a0_d    = 1'b0;
          d_d     = head[15:8];
          cs_n_d  = 1'b0;
          wr_n_d  = 1'b0;
          cnt_d   = STB_LOAD;
          state_d = ADDR_STB;
        end
      end
      ADDR_STB: begin
        if (cnt_q == '0) begin
          cnt_d   = AGAP_LOAD;
          state_d = ADDR_GAP;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
      end
      ADDR_GAP: begin
        if (cnt_q == '0) begin
          a0_d    = 1'b1;
          d_d     = data_q;
          cs_n_d  = 1'b0;
          wr_n_d  = 1'b0;
          cnt_d   = STB_LOAD;
          state_d = DATA_STB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA_STB: begin
        if (cnt_q == '0) begin
          cnt_d   = DGAP_LOAD;
          state_d = DATA_GAP;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
      end
      DATA_GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        cnt_d   = BOOT_LOAD;
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      cnt_q   <= BOOT_LOAD;
      o_CS_n  <= 1'b1;
      o_WR_n  <= 1'b1;
      o_A0    <= 1'b0;
      o_D     <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_CS_n  <= cs_n_d;
      o_WR_n  <= wr_n_d;
      o_A0    <= a0_d;
      o_D     <= d_d;
    end
  end

  // Latched data byte for the second strobe; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_ym2413_bus_write_sequencer.sv
// Self-checking bench for ym2413_bus_write_sequencer. Accepted requests push
// their expected address and data strobes into a scoreboard queue; a monitor
// on the falling clock edge pops and compares whenever WR_n falls, and also
// checks strobe length, address gap, A0/D stability and CS_n spacing.
module tb_ym2413_bus_write_sequencer;

  localparam int STROBE_CYCLES = 4;
  localparam int ADDR_WAIT     = 12;
  localparam int DATA_WAIT     = 84;
  localparam int BOOT_WAIT     = 1024;
  localparam int SPACING       = 1 + 2*STROBE_CYCLES + ADDR_WAIT + DATA_WAIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_wr_valid = 1'b0;
  logic [7:0] i_wr_addr = 8'h00;
  logic [7:0] i_wr_data = 8'h00;
  logic       o_wr_ready;
  logic       o_CS_n;
  logic       o_WR_n;
  logic       o_A0;
  logic [7:0] o_D;
  logic       o_busy;
  logic       o_overflow;

  ym2413_bus_write_sequencer #(
    .FIFO_DEPTH   (4),
    .STROBE_CYCLES(STROBE_CYCLES),
    .ADDR_WAIT    (ADDR_WAIT),
    .DATA_WAIT    (DATA_WAIT),
    .BOOT_WAIT    (BOOT_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_valid(i_wr_valid),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .o_wr_ready(o_wr_ready),
    .o_CS_n    (o_CS_n),
    .o_WR_n    (o_WR_n),
    .o_A0      (o_A0),
    .o_D       (o_D),
    .o_busy    (o_busy),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       a0;
    logic [7:0] d;
  } strobe_t;

  strobe_t     exp_q[$];
  int unsigned addr_fall_cyc[$];
  int          checks = 0;
  int          passed = 0;
  int unsigned cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  logic        prev_wr = 1'b1;
  int          low_cnt = 0;
  int          gap_cnt = 0;
  logic [8:0]  held = 9'h000;
  bit          have_last = 1'b0;
  int unsigned last_fall = 0;
  strobe_t     mon_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_wr   = 1'b1;
      low_cnt   = 0;
      gap_cnt   = 0;
      have_last = 1'b0;
    end else begin
      chk("cs_eq_wr", o_CS_n, o_WR_n);
      if (prev_wr && !o_WR_n) begin
        chk("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk(mon_e.a0 ? "data_strobe_a0_d" : "addr_strobe_a0_d", {o_A0, o_D}, mon_e);
        end
        if (o_A0) begin
          chk("addr_gap", gap_cnt, ADDR_WAIT);
        end else begin
          if (have_last) begin
            chk("min_spacing", (cyc - last_fall) >= SPACING, 1);
          end
          have_last = 1'b1;
          last_fall = cyc;
          addr_fall_cyc.push_back(cyc);
        end
        held    = {o_A0, o_D};
        low_cnt = 0;
      end else if (!prev_wr && !o_WR_n) begin
        chk("hold_while_low", {o_A0, o_D}, held);
      end
      if (!o_WR_n) begin
        low_cnt++;
      end
      if (!prev_wr && o_WR_n) begin
        chk("strobe_len", low_cnt, STROBE_CYCLES);
        gap_cnt = 0;
      end
      if (o_WR_n) begin
        gap_cnt++;
      end
      prev_wr = o_WR_n;
    end
  end

  // One request cycle: inputs change just after the rising edge and the
  // accept/drop outcome is checked on the following falling edge.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] d,
                       input logic exp_acc);
    @(posedge clk);
    #1;
    i_wr_valid = v;
    i_wr_addr  = a;
    i_wr_data  = d;
    @(negedge clk);
    if (v) begin
      chk("wr_ready", o_wr_ready, exp_acc);
      chk("overflow", o_overflow, !exp_acc);
      if (exp_acc) begin
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b1, d});
      end
    end else begin
      chk("overflow_idle", o_overflow, 0);
    end
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (o_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", n < budget, 1);
  endtask

  // Called on a falling edge right after rst_n is released.
  task automatic check_boot();
    int   first_ready;
    logic early_bad;
    first_ready = -1;
    early_bad   = 1'b0;
    i_wr_valid  = 1'b1;
    i_wr_addr   = 8'h77;
    i_wr_data   = 8'h88;
    for (int i = 1; i <= BOOT_WAIT + 8; i++) begin
      @(negedge clk);
      if (i <= 8 && (o_overflow !== 1'b0 || o_wr_ready !== 1'b0)) early_bad = 1'b1;
      if (i == 8) i_wr_valid = 1'b0;
      if (o_wr_ready === 1'b1 && first_ready < 0) first_ready = i;
    end
    chk("boot_push_ignored", early_bad, 0);
    chk("boot_ready_cycle", first_ready, BOOT_WAIT);
    chk("busy_after_boot", o_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with a request held high.
    rst_n      = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_addr  = 8'h33;
    i_wr_data  = 8'h44;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", o_CS_n, 1);
    chk("rst_wr_n", o_WR_n, 1);
    chk("rst_a0", o_A0, 0);
    chk("rst_d", o_D, 8'h00);
    chk("rst_ready", o_wr_ready, 0);
    chk("rst_busy", o_busy, 1);
    chk("rst_overflow", o_overflow, 0);
    rst_n = 1'b1;
    check_boot();

    // Single write.
    drive(1'b1, 8'h10, 8'hAB, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    wait_idle(300, n);
    chk("busy_duration", n, SPACING);

    // Four back-to-back writes.
    addr_fall_cyc.delete();
    drive(1'b1, 8'h01, 8'h11, 1'b1);
    drive(1'b1, 8'h02, 8'h22, 1'b1);
    drive(1'b1, 8'h03, 8'h33, 1'b1);
    drive(1'b1, 8'h04, 8'h44, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    wait_idle(600, n);
    chk("b2b_falls", addr_fall_cyc.size(), 4);
    if (addr_fall_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        chk("b2b_spacing", addr_fall_cyc[i] - addr_fall_cyc[i-1], SPACING);
      end
    end

    // Fill while a write is in flight, then collide with the IDLE pop.
    drive(1'b1, 8'hA0, 8'h0A, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'hB1, 8'h1B, 1'b1);
    drive(1'b1, 8'hC2, 8'h2C, 1'b1);
    drive(1'b1, 8'hD3, 8'h3D, 1'b1);
    drive(1'b1, 8'hE4, 8'h4E, 1'b1);
    drive(1'b1, 8'hF5, 8'h5F, 1'b0);
    drive(1'b1, 8'hF6, 8'h6F, 1'b0);
    repeat (97) drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h66, 8'h06, 1'b0);
    drive(1'b1, 8'h77, 8'h07, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    wait_idle(800, n);

    // Reset during a data strobe.
    drive(1'b1, 8'h20, 8'h5C, 1'b1);
    drive(1'b1, 8'h21, 8'h5D, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    n = 0;
    while (!(o_WR_n === 1'b0 && o_A0 === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_data_stb", n < 200, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr_n", o_WR_n, 1);
    chk("async_rst_cs_n", o_CS_n, 1);
    chk("async_rst_ready", o_wr_ready, 0);
    chk("async_rst_busy", o_busy, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_hold_a0", o_A0, 0);
    chk("rst_hold_d", o_D, 8'h00);
    rst_n = 1'b1;
    check_boot();

    // Normal operation after the mid-strobe reset.
    drive(1'b1, 8'h30, 8'h99, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    wait_idle(300, n);
    chk("busy_duration_after_rst", n, SPACING);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
